// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Bundles the MEM-stage micro-op handshake, the data-memory port and the
// write-back result of mem_access_unit.
//   slave  modport : used by mem_access_unit
//   master modport : used by whatever drives the micro-ops and models memory
// Parameters: XLEN (data width, 32 or 64), ADDR_W (address width).
//
// Handshake semantics: a micro-op transfers on a rising edge where
// in_valid && in_ready. The producer holds the micro-op fields stable while
// in_valid is high and not yet accepted. On the memory side dmem_req stays
// high with all request fields stable until the cycle dmem_ack is seen;
// dmem_rdata is sampled in that same cycle. out_valid is a one-cycle pulse
// with no back-pressure; misalign and bus_err only qualify it.
interface mem_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        mem_op;
  logic              mem_wr;
  logic              load_sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;

  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN/8-1:0] dmem_be;
  logic [ADDR_W-1:0] dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic              dmem_ack;
  logic [XLEN-1:0]   dmem_rdata;

  logic              out_valid;
  logic [XLEN-1:0]   out_data;
  logic              misalign;
  logic              bus_err;

  modport slave (
    input  in_valid, mem_op, mem_wr, load_sign_ext, addr, wdata,
    input  dmem_ack, dmem_rdata,
    output in_ready,
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output out_valid, out_data, misalign, bus_err
  );

  modport master (
    output in_valid, mem_op, mem_wr, load_sign_ext, addr, wdata,
    output dmem_ack, dmem_rdata,
    input  in_ready,
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  out_valid, out_data, misalign, bus_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM-stage data-memory access unit. Accepts one decoded memory micro-op,
// either returns the ALU value (forward op), flags a misaligned access, or
// runs one request/acknowledge transaction on the data-memory port and
// returns the formatted load data (or 0 for a store / bus error).
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : mem_access_unit_if.slave (micro-op in, dmem port, result out)
//   dbg_state : current FSM state (0 = IDLE, 1 = WAIT)
// Parameters: XLEN (32/64), ADDR_W, TIMEOUT (WAIT cycles before bus error,
// 0 disables the timeout).
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_unit_if.slave      bus,
  output logic                  dbg_state
);
  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int XB = $clog2(XLEN);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  state_e            state, state_d;
  logic [31:0]       cnt, cnt_d;
  logic              req_q, req_d, we_q, we_d;
  logic [NB-1:0]     be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              ov_q, ov_d, mis_q, mis_d, berr_q, berr_d;
  logic [XLEN-1:0]   od_q, od_d;
  // Access attributes kept for formatting the load data on ack.
  logic [1:0]        size_q, size_d;
  logic [LB-1:0]     off_q, off_d;
  logic              sext_q, sext_d, wr_q, wr_d;

  // ---------------- micro-op decode ----------------
  logic              fwd;
  logic [1:0]        size;
  logic [LB-1:0]     off;
  logic [LB-1:0]     size_mask;
  logic              mis;
  logic [NB-1:0]     be_new;
  logic [XLEN-1:0]   wdata_new;
  logic [ADDR_W-1:0] addr_new;

  always_comb begin
    fwd  = 1'b0;
    size = 2'd0;
    case (bus.mem_op)
      3'b000:  size = 2'd0;
      3'b001:  size = 2'd1;
      3'b010:  size = 2'd2;
      // dword only exists on a 64-bit datapath; otherwise it is a forward op
      3'b011:  if (XLEN == 64) size = 2'd3; else fwd = 1'b1;
      default: fwd = 1'b1;
    endcase
  end

  assign off       = bus.addr[LB-1:0];
  assign size_mask = LB'((4'd1 << size) - 4'd1);
  assign mis       = |(off & size_mask);
  assign wdata_new = bus.wdata << {off, 3'b000};
  assign addr_new  = bus.addr & ~ADDR_W'(NB - 1);

  // Lanes off .. off+nbytes-1 are enabled.
  always_comb begin
    be_new = '0;
    for (int i = 0; i < NB; i++) begin
      be_new[i] = (i >= int'(off)) && (i < int'(off) + (1 << size));
    end
  end

  // ---------------- load data formatting ----------------
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_fmt;
  logic [XB-1:0]   msb;
  logic            ext;

  assign shifted = bus.dmem_rdata >> {off_q, 3'b000};
  assign msb     = XB'((32'd8 << size_q) - 32'd1);
  assign ext     = sext_q & shifted[msb];

  always_comb begin
    load_fmt = '0;
    for (int i = 0; i < XLEN; i++) begin
      load_fmt[i] = (i <= int'(msb)) ? shifted[i] : ext;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= '0;
      sext_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      size_q  <= size_d;
      off_q   <= off_d;
      sext_q  <= sext_d;
      wr_q    <= wr_d;
    end
  end

  // ---------------- FSM: next state / next outputs ----------------
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    off_d   = off_q;
    sext_d  = sext_q;
    wr_d    = wr_q;
    ov_d    = 1'b0;
    od_d    = '0;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (fwd) begin
            ov_d = 1'b1;
            od_d = XLEN'(bus.addr);
          end else if (mis) begin
            ov_d  = 1'b1;
            mis_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = bus.mem_wr;
            be_d    = be_new;
            addr_d  = addr_new;
            wdata_d = wdata_new;
            size_d  = size;
            off_d   = off;
            sext_d  = bus.load_sign_ext;
            wr_d    = bus.mem_wr;
          end
        end
      end
      WAIT: begin
        // ack is checked first so it wins over a timeout in the same cycle
        if (bus.dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          ov_d    = 1'b1;
          od_d    = wr_q ? '0 : load_fmt;
        end else if ((TIMEOUT > 0) && (cnt == 32'(TIMEOUT - 1))) begin
          state_d = IDLE;
          req_d   = 1'b0;
          ov_d    = 1'b1;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_be    = be_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.out_valid  = ov_q;
  assign bus.out_data   = od_q;
  assign bus.misalign   = mis_q;
  assign bus.bus_err    = berr_q;
  assign dbg_state      = state;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed bench for mem_access_unit (XLEN=32, ADDR_W=32, TIMEOUT=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_access_unit;
  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  always #5 clk = ~clk;

  mem_access_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  // {bus_err, misalign, out_data} expected for each out_valid pulse
  logic [XLEN+1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check_eq("unexpected_out_valid", bus.out_valid, 1'b0);
        else check_eq("out_result", {bus.bus_err, bus.misalign, bus.out_data}, exp_q.pop_front());
      end else begin
        check_eq("qual_without_valid", {bus.bus_err, bus.misalign}, 2'b00);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [2:0] op, input logic wr, input logic sext,
                          input logic [31:0] a, input logic [31:0] wd);
    bus.in_valid      = 1'b1;
    bus.mem_op        = op;
    bus.mem_wr        = wr;
    bus.load_sign_ext = sext;
    bus.addr          = a;
    bus.wdata         = wd;
  endtask

  task automatic drop_op();
    bus.in_valid      = 1'b0;
    bus.mem_op        = 3'b111;
    bus.mem_wr        = 1'b0;
    bus.load_sign_ext = 1'b0;
    bus.addr          = '0;
    bus.wdata         = '0;
  endtask

  // Aligned access acked k cycles after dmem_req rises. Starts and ends on a negedge.
  task automatic aligned_access(input string tag, input logic [2:0] op, input logic wr,
                                input logic sext, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdata, input int k,
                                input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic [31:0] e_out);
    drive_op(op, wr, sext, a, wd);
    exp_q.push_back({2'b00, e_out});
    @(negedge clk);
    drop_op();
    check_eq({tag, "_req"}, bus.dmem_req, 1'b1);
    check_eq({tag, "_we"}, bus.dmem_we, wr);
    check_eq({tag, "_addr"}, bus.dmem_addr, e_addr);
    check_eq({tag, "_be"}, bus.dmem_be, e_be);
    check_eq({tag, "_wdata"}, bus.dmem_wdata, e_wdata);
    check_eq({tag, "_in_ready_low"}, bus.in_ready, 1'b0);
    check_eq({tag, "_dbg_wait"}, dbg_state, 1'b1);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check_eq({tag, "_req_held"}, bus.dmem_req, 1'b1);
      check_eq({tag, "_addr_held"}, bus.dmem_addr, e_addr);
      check_eq({tag, "_no_early_valid"}, bus.out_valid, 1'b0);
    end
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = rdata;
    @(negedge clk);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    check_eq({tag, "_valid"}, bus.out_valid, 1'b1);
    check_eq({tag, "_req_drop"}, bus.dmem_req, 1'b0);
    check_eq({tag, "_in_ready_back"}, bus.in_ready, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int req_cycles;
    logic seen;
    rst            = 1'b1;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    drop_op();
    repeat (3) @(negedge clk);

    // reset state
    check_eq("rst_in_ready", bus.in_ready, 1'b1);
    check_eq("rst_dmem_req", bus.dmem_req, 1'b0);
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_fields", {bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata}, '0);
    check_eq("rst_result", {bus.bus_err, bus.misalign, bus.out_data}, '0);
    rst = 1'b0;
    @(negedge clk);

    // three back-to-back forward ops
    for (int i = 0; i < 3; i++) begin
      drive_op(3'b111, 1'b1, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF);
      exp_q.push_back({2'b00, 32'h1234_5678});
      @(negedge clk);
      check_eq("fwd_valid", bus.out_valid, 1'b1);
      check_eq("fwd_no_req", bus.dmem_req, 1'b0);
      check_eq("fwd_in_ready", bus.in_ready, 1'b1);
    end
    drop_op();
    @(negedge clk);
    check_eq("fwd_valid_ends", bus.out_valid, 1'b0);

    // dword code on a 32-bit datapath behaves as forward
    drive_op(3'b011, 1'b0, 1'b0, 32'h0000_0ABC, 32'h0);
    exp_q.push_back({2'b00, 32'h0000_0ABC});
    @(negedge clk);
    drop_op();
    check_eq("dword32_no_req", bus.dmem_req, 1'b0);

    // byte store at 0x103, ack after 3 wait cycles (also the last cycle before timeout)
    aligned_access("sb", 3'b000, 1'b1, 1'b0, 32'h0000_0103, 32'h0000_00AB, 32'h0, 3,
                   32'h0000_0100, 4'b1000, 32'hAB00_0000, 32'h0);

    // half loads at 0x2, immediate ack
    aligned_access("lh_s", 3'b001, 1'b0, 1'b1, 32'h0000_0002, 32'h0, 32'h8001_0000, 0,
                   32'h0, 4'b1100, 32'h0, 32'hFFFF_8001);
    aligned_access("lh_u", 3'b001, 1'b0, 1'b0, 32'h0000_0002, 32'h0, 32'h8001_0000, 0,
                   32'h0, 4'b1100, 32'h0, 32'h0000_8001);

    // signed byte load from lane 1, word load with one wait cycle
    aligned_access("lb_s", 3'b000, 1'b0, 1'b1, 32'h0000_0201, 32'h0, 32'h0000_9C00, 1,
                   32'h0000_0200, 4'b0010, 32'h0, 32'hFFFF_FF9C);
    aligned_access("lw", 3'b010, 1'b0, 1'b1, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 1,
                   32'h0000_0008, 4'b1111, 32'h0, 32'hDEAD_BEEF);

    // misaligned word and half
    drive_op(3'b010, 1'b0, 1'b0, 32'h0000_0006, 32'h0);
    exp_q.push_back({2'b01, 32'h0});
    @(negedge clk);
    check_eq("mis_w_valid", bus.out_valid, 1'b1);
    check_eq("mis_w_no_req", bus.dmem_req, 1'b0);
    check_eq("mis_w_in_ready", bus.in_ready, 1'b1);
    drive_op(3'b001, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_1234);
    exp_q.push_back({2'b01, 32'h0});
    @(negedge clk);
    drop_op();
    check_eq("mis_h_valid", bus.out_valid, 1'b1);
    check_eq("mis_h_no_req", bus.dmem_req, 1'b0);

    // ack outside WAIT is ignored
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    check_eq("idle_ack_ignored", bus.out_valid, 1'b0);
    check_eq("idle_ack_state", dbg_state, 1'b0);

    // timeout: no ack at all
    drive_op(3'b010, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
    exp_q.push_back({2'b10, 32'h0});
    @(negedge clk);
    drop_op();
    req_cycles = 0;
    seen       = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      if (bus.dmem_req) req_cycles++;
      if (bus.out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check_eq("to_seen", seen, 1'b1);
    check_eq("to_req_cycles", req_cycles, TIMEOUT);
    check_eq("to_bus_err", bus.bus_err, 1'b1);
    check_eq("to_in_ready", bus.in_ready, 1'b1);

    // next op after a timeout proceeds normally
    aligned_access("sw_after_to", 3'b010, 1'b1, 1'b0, 32'h0000_0044, 32'h1122_3344,
                   32'h0, 1, 32'h0000_0044, 4'b1111, 32'h1122_3344, 32'h0);

    // reset two cycles into WAIT aborts the access with no result
    drive_op(3'b010, 1'b0, 1'b0, 32'h0000_0020, 32'h0);
    @(negedge clk);
    drop_op();
    check_eq("rw_req", bus.dmem_req, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rw_req_drop", bus.dmem_req, 1'b0);
    check_eq("rw_out_valid", bus.out_valid, 1'b0);
    check_eq("rw_in_ready", bus.in_ready, 1'b1);
    check_eq("rw_fields", {bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata}, '0);
    check_eq("rw_result", {bus.bus_err, bus.misalign, bus.out_data}, '0);
    repeat (6) @(negedge clk);
    check_eq("rw_no_late_valid", bus.out_valid, 1'b0);

    // final report
    check_eq("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
